clint_axi_initiator: RTL and testbench
======================================

CLINT_AXI_INITIATOR -- requirements
Module: clint_axi_initiator

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64: AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64: AXI data width; AXI_STRB_WIDTH = AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 10: AXI ID width.
REQ-004 SHALL have parameter AXI_ID, default 0: constant ID driven on aw_id/ar_id and expected on b_id/r_id.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: response-wait limit (used only with CLINT_INIT_TIMEOUT_EN).
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  AXI_ADDR_WIDTH  target byte address (e.g. CLINT msip/mtimecmp/mtime).
REQ-011 req_wdata / req_strb  input  AXI_DATA_WIDTH / AXI_STRB_WIDTH  write data and byte strobes.
REQ-012 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-013 rsp_rdata  output  AXI_DATA_WIDTH  read data (0 for writes and errors).
REQ-014 rsp_err  output  1  transaction error.
REQ-015 timeout  output  1  sticky timeout flag (constant 0 without CLINT_INIT_TIMEOUT_EN).
REQ-016 AW channel  output  aw_id, aw_addr, aw_len[7:0], aw_size[2:0], aw_burst[1:0], aw_lock, aw_cache[3:0], aw_prot[2:0], aw_qos[3:0], aw_atop[5:0], aw_region[3:0], aw_user[0], aw_valid; input aw_ready.
REQ-017 W channel  output  w_data, w_strb, w_last, w_user[0], w_valid; input w_ready.
REQ-018 B channel  input  b_id, b_resp[1:0], b_user[0], b_valid; output b_ready.
REQ-019 AR channel  output  same fields as AW minus aw_atop, prefixed ar_; input ar_ready.
REQ-020 R channel  input  r_id, r_data, r_resp[1:0], r_last, r_user[0], r_valid; output r_ready.

Function
REQ-021 FSM states SHALL be IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP, DRAIN; one transaction outstanding at a time.
REQ-022 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready, addr/wdata/strb/we SHALL be registered and FSM -> WR_ADDR (we=1) or RD_ADDR (we=0).
REQ-023 Fixed fields SHALL be: len=0, size=$clog2(AXI_STRB_WIDTH), burst=2'b01, w_last=1, id=AXI_ID, all other AW/AR/W fields and users 0.
REQ-024 WR_ADDR: aw_valid and w_valid SHALL assert the cycle after acceptance; each SHALL hold until its own handshake, then drop; FSM -> WR_RESP the cycle after both complete (same-cycle or either order).
REQ-025 WR_RESP: b_ready=1; on b_valid, rsp_err = b_resp[1] | (b_id != AXI_ID), rsp_rdata=0, FSM -> RESP.
REQ-026 RD_ADDR: ar_valid held until ar_ready, then RD_DATA; r_ready=1; on r_valid capture r_data, rsp_err = r_resp[1] | ~r_last | (r_id != AXI_ID); rsp_rdata=0 on error; -> RESP.
REQ-027 RESP: rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready; then IDLE (req_ready=1 next cycle).
REQ-028 Minimum latency: accept at cycle 0, address/data valid cycle 1, response cycle 2, rsp_valid cycle 3.
REQ-029 Valid signals SHALL never drop before handshake; b_ready/r_ready SHALL be 0 outside WR_RESP/RD_DATA/DRAIN.

Reset
REQ-030 On rstn=0, FSM -> IDLE asynchronously; all valid/ready outputs 0 except req_ready=1 after release; rsp_rdata=0, rsp_err=0, timeout=0.
REQ-031 Reset mid-transaction SHALL abandon it with no response; no pending state survives.

Configuration
REQ-032 With CLINT_INIT_TIMEOUT_EN defined, a counter SHALL run in WR_RESP/RD_DATA; at TIMEOUT_CYCLES cycles without response, rsp_err=1, rsp_rdata=0, timeout set (sticky until reset), FSM -> RESP then DRAIN.
REQ-033 DRAIN: b_ready (write) or r_ready (read) held 1, req_ready=0; late response discarded, then IDLE.
REQ-034 Without CLINT_INIT_TIMEOUT_EN: no counter, no DRAIN entry, timeout tied 0, waits indefinitely.

Verification
REQ-035 Write 0x0200_4000 data 0x10 strb 0xFF, aw_ready/w_ready/b_valid immediate, OKAY -> rsp_valid cycle 3, rsp_err=0, aw_size=3, aw_len=0.
REQ-036 Write with w_ready 3 cycles after aw_ready -> aw_valid drops after its handshake, w_valid held, single B, rsp_err=0.
REQ-037 Read 0x0200_BFF8, r_data 0x1234, r_last=1, OKAY -> rsp_rdata=0x1234, rsp_err=0.
REQ-038 Read returning SLVERR, or r_last=0 -> rsp_err=1, rsp_rdata=0.
REQ-039 With CLINT_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=8, no B -> rsp_err=1 and timeout=1 after 8 cycles; late B drained; next request accepted.
REQ-040 rstn low during WR_RESP -> all valids 0, req_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/clint_axi_initiator.sv
// clint_axi_initiator: single-outstanding AXI4 master for CLINT register access (optional response timeout via CLINT_INIT_TIMEOUT_EN)
module clint_axi_initiator #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] req_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      timeout,
    output logic [AXI_ID_WIDTH-1:0]   aw_id,
    output logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    output logic [7:0]                aw_len,
    output logic [2:0]                aw_size,
    output logic [1:0]                aw_burst,
    output logic                      aw_lock,
    output logic [3:0]                aw_cache,
    output logic [2:0]                aw_prot,
    output logic [3:0]                aw_qos,
    output logic [5:0]                aw_atop,
    output logic [3:0]                aw_region,
    output logic [0:0]                aw_user,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [AXI_DATA_WIDTH-1:0] w_data,
    output logic [AXI_STRB_WIDTH-1:0] w_strb,
    output logic                      w_last,
    output logic [0:0]                w_user,
    output logic                      w_valid,
    input  logic                      w_ready,
    input  logic [AXI_ID_WIDTH-1:0]   b_id,
    input  logic [1:0]                b_resp,
    input  logic [0:0]                b_user,
    input  logic                      b_valid,
    output logic                      b_ready,
    output logic [AXI_ID_WIDTH-1:0]   ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]                ar_len,
    output logic [2:0]                ar_size,
    output logic [1:0]                ar_burst,
    output logic                      ar_lock,
    output logic [3:0]                ar_cache,
    output logic [2:0]                ar_prot,
    output logic [3:0]                ar_qos,
    output logic [3:0]                ar_region,
    output logic [0:0]                ar_user,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   r_id,
    input  logic [AXI_DATA_WIDTH-1:0] r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_last,
    input  logic [0:0]                r_user,
    input  logic                      r_valid,
    output logic                      r_ready
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP, DRAIN} state_t;

    localparam logic [AXI_ID_WIDTH-1:0] ID   = AXI_ID_WIDTH'(AXI_ID);
    localparam logic [2:0]              SIZE = 3'($clog2(AXI_STRB_WIDTH));

    state_t state, next;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_STRB_WIDTH-1:0] strb_q;
    logic we_q, aw_done, w_done;
    logic b_err, r_err, to_hit, drain_pend;
    logic unused_in;

    assign b_err = b_resp[1] | (b_id != ID);
    assign r_err = r_resp[1] | ~r_last | (r_id != ID);
    assign unused_in = ^{b_user, r_user, b_resp[0], r_resp[0]};

    assign aw_id     = ID;
    assign aw_addr   = addr_q;
    assign aw_len    = 8'd0;
    assign aw_size   = SIZE;
    assign aw_burst  = 2'b01;
    assign aw_lock   = 1'b0;
    assign aw_cache  = 4'd0;
    assign aw_prot   = 3'd0;
    assign aw_qos    = 4'd0;
    assign aw_atop   = 6'd0;
    assign aw_region = 4'd0;
    assign aw_user   = 1'b0;
    assign w_data    = wdata_q;
    assign w_strb    = strb_q;
    assign w_last    = 1'b1;
    assign w_user    = 1'b0;
    assign ar_id     = ID;
    assign ar_addr   = addr_q;
    assign ar_len    = 8'd0;
    assign ar_size   = SIZE;
    assign ar_burst  = 2'b01;
    assign ar_lock   = 1'b0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_qos    = 4'd0;
    assign ar_region = 4'd0;
    assign ar_user   = 1'b0;

`ifdef CLINT_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic waiting, timeout_q, drain_q;

    assign waiting    = (state == WR_RESP & ~b_valid) | (state == RD_DATA & ~r_valid);
    assign to_hit     = waiting & (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_q;
    assign drain_pend = drain_q;

    // Count response-less wait cycles; on expiry latch the sticky flag and remember a late beat is still owed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            cnt       <= waiting & ~to_hit ? cnt + 1'b1 : '0;
            timeout_q <= timeout_q | to_hit;
            drain_q   <= to_hit | (drain_q & state != IDLE);
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign to_hit     = 1'b0;
    assign drain_pend = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= next;
    end

    // Next state and handshake outputs
    always_comb begin
        next      = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rstn;
                if (req_valid) next = req_we ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                aw_valid = ~aw_done;
                w_valid  = ~w_done;
                if ((aw_done | aw_ready) & (w_done | w_ready)) next = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid | to_hit) next = RESP;
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) next = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (r_valid | to_hit) next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next = drain_pend ? DRAIN : IDLE;
            end
            DRAIN: begin
                b_ready = we_q;
                r_ready = ~we_q;
                if (we_q ? b_valid : r_valid) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Capture the request, track write-channel handshakes, and record the response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            we_q      <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_ready & req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                strb_q  <= req_strb;
                we_q    <= req_we;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_valid & aw_ready) aw_done <= 1'b1;
            if (w_valid & w_ready) w_done <= 1'b1;
            if (state == WR_RESP & b_valid) begin
                rsp_err   <= b_err;
                rsp_rdata <= '0;
            end else if (state == RD_DATA & r_valid) begin
                rsp_err   <= r_err;
                rsp_rdata <= r_err ? '0 : r_data;
            end else if (to_hit) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_clint_axi_initiator.sv
// tb_clint_axi_initiator: randomized and directed checks of the CLINT AXI initiator against a transaction-level model
module tb_clint_axi_initiator;
    logic clk = 1'b0, rstn = 1'b0;
    logic req_valid = 0, req_ready, req_we = 0;
    logic [63:0] req_addr = 0, req_wdata = 0;
    logic [7:0] req_strb = 0;
    logic rsp_valid, rsp_ready = 0, rsp_err, timeout;
    logic [63:0] rsp_rdata;
    logic [9:0] aw_id, ar_id, b_id = 0, r_id = 0;
    logic [63:0] aw_addr, ar_addr, w_data, r_data = 0;
    logic [7:0] aw_len, ar_len, w_strb;
    logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0] aw_burst, ar_burst, b_resp = 0, r_resp = 0;
    logic aw_lock, ar_lock, w_last, r_last = 0;
    logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic [5:0] aw_atop;
    logic [0:0] aw_user, ar_user, w_user, b_user = 0, r_user = 0;
    logic aw_valid, aw_ready = 0, w_valid, w_ready = 0, b_valid = 0, b_ready;
    logic ar_valid, ar_ready = 0, r_valid = 0, r_ready;
    int checks = 0, failures = 0;

    clint_axi_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .timeout(timeout),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_atop(aw_atop),
        .aw_region(aw_region), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user), .w_valid(w_valid),
        .w_ready(w_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid),
        .b_ready(b_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos),
        .ar_region(ar_region), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_err, timeout} !== 8'b0 || rsp_rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b rdata=%h exp=0", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_err, timeout}, rsp_rdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
    endtask

    // One full transaction against a slave with the given delays/response; the model predicts result and latency
    task automatic do_txn(input bit we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] st,
                          input int aw_d, input int w_d, input int rsp_d, input logic [1:0] resp,
                          input logic [9:0] id, input bit last, input logic [63:0] rd, input int rr_d,
                          input string name);
        int t, t_aw, t_w, t_ar, t_resp, t_rsp, exp_t, m;
        logic exp_err;
        logic [63:0] exp_rd, hold_rd;
        logic hold_err;
        exp_err = we ? (resp[1] | (id != 0)) : (resp[1] | !last | (id != 0));
        exp_rd = (we || exp_err) ? 64'd0 : rd;
        m = aw_d > w_d ? aw_d : w_d;
        exp_t = we ? m + 3 + rsp_d : aw_d + rsp_d + 3;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready_idle got=%b exp=1", name, req_ready);
        end
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_strb = st;
        @(negedge clk);
        req_valid = 0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom}; req_strb = 8'($urandom);
        t_aw = -1; t_w = -1; t_ar = -1; t_resp = -1; t_rsp = -1; t = 1;
        while (t_rsp < 0 && t < 400) begin
            aw_ready = 0; w_ready = 0; ar_ready = 0;
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s req_ready_busy t=%0d got=%b exp=0", name, t, req_ready);
            end
            if (rsp_valid === 1'b1) t_rsp = t;
            else if (we) begin
                checks++;
                if (aw_valid !== (t_aw < 0) || w_valid !== (t_w < 0) || ar_valid !== 1'b0 || r_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s wr_valids t=%0d got aw=%b w=%b ar=%b rr=%b exp aw=%b w=%b ar=0 rr=0", name, t, aw_valid, w_valid, ar_valid, r_ready, t_aw < 0, t_w < 0);
                end
                if (t_aw < 0 && t >= 1 + aw_d) begin
                    checks++;
                    if ({aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_atop, aw_region, aw_user} !==
                        {a, 10'd0, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 6'd0, 4'd0, 1'b0}) begin
                        failures++;
                        $display("FAIL %s aw_fields addr=%h id=%h len=%h size=%h burst=%h exp addr=%h id=0 len=0 size=3 burst=1", name, aw_addr, aw_id, aw_len, aw_size, aw_burst, a);
                    end
                    aw_ready = 1; t_aw = t;
                end
                if (t_w < 0 && t >= 1 + w_d) begin
                    checks++;
                    if ({w_data, w_strb, w_last, w_user} !== {wd, st, 1'b1, 1'b0}) begin
                        failures++;
                        $display("FAIL %s w_fields data=%h strb=%h last=%b exp data=%h strb=%h last=1", name, w_data, w_strb, w_last, wd, st);
                    end
                    w_ready = 1; t_w = t;
                end
                b_valid = t_aw >= 0 && t_w >= 0 && t >= m + 2 + rsp_d && t_resp < 0;
                b_resp = resp; b_id = id;
                if (b_valid) begin
                    t_resp = t;
                    checks++;
                    if (b_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL %s b_ready got=%b exp=1", name, b_ready);
                    end
                end
            end else begin
                checks++;
                if (ar_valid !== (t_ar < 0) || aw_valid !== 1'b0 || w_valid !== 1'b0 || b_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s rd_valids t=%0d got ar=%b aw=%b w=%b br=%b exp ar=%b", name, t, ar_valid, aw_valid, w_valid, b_ready, t_ar < 0);
                end
                if (t_ar < 0 && t >= 1 + aw_d) begin
                    checks++;
                    if ({ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user} !==
                        {a, 10'd0, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}) begin
                        failures++;
                        $display("FAIL %s ar_fields addr=%h id=%h len=%h size=%h exp addr=%h id=0 len=0 size=3", name, ar_addr, ar_id, ar_len, ar_size, a);
                    end
                    ar_ready = 1; t_ar = t;
                end
                r_valid = t_ar >= 0 && t >= t_ar + 1 + rsp_d && t_resp < 0 && t_ar < t;
                r_resp = resp; r_id = id; r_last = last; r_data = rd;
                if (r_valid) begin
                    t_resp = t;
                    checks++;
                    if (r_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL %s r_ready got=%b exp=1", name, r_ready);
                    end
                end
            end
            if (t_rsp < 0) begin
                @(negedge clk);
                t++;
            end
        end
        b_valid = 0; r_valid = 0; aw_ready = 0; w_ready = 0; ar_ready = 0;
        checks++;
        if (t_rsp !== exp_t || rsp_err !== exp_err || rsp_rdata !== exp_rd) begin
            failures++;
            $display("FAIL %s rsp cycle=%0d err=%b rdata=%h exp cycle=%0d err=%b rdata=%h", name, t_rsp, rsp_err, rsp_rdata, exp_t, exp_err, exp_rd);
        end
        hold_rd = rsp_rdata; hold_err = rsp_err;
        for (int k = 0; k < rr_d; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== hold_rd || rsp_err !== hold_err) begin
                failures++;
                $display("FAIL %s rsp_hold valid=%b err=%b rdata=%h exp valid=1 err=%b rdata=%h", name, rsp_valid, rsp_err, rsp_rdata, hold_err, hold_rd);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s rsp_done rsp_valid=%b req_ready=%b exp 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_directed();
        do_txn(1, 64'h0200_4000, 64'h10, 8'hFF, 0, 0, 0, 2'b00, 10'd0, 1, 0, 0, "wr_min_latency");
        do_txn(1, 64'h0200_4008, 64'hDEAD_BEEF, 8'h0F, 0, 3, 0, 2'b00, 10'd0, 1, 0, 1, "wr_w_late");
        do_txn(1, 64'h0200_4010, 64'h5, 8'hFF, 2, 0, 1, 2'b00, 10'd0, 1, 0, 0, "wr_aw_late");
        do_txn(0, 64'h0200_BFF8, 0, 0, 0, 0, 0, 2'b00, 10'd0, 1, 64'h1234, 0, "rd_okay");
        do_txn(0, 64'h0200_BFF8, 0, 0, 1, 0, 2, 2'b10, 10'd0, 1, 64'h55, 2, "rd_slverr");
        do_txn(0, 64'h0200_0000, 0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 64'h77, 0, "rd_no_last");
        do_txn(0, 64'h0200_0000, 0, 0, 0, 0, 0, 2'b00, 10'd3, 1, 64'h88, 0, "rd_bad_id");
        do_txn(1, 64'h0200_4000, 64'h1, 8'h01, 0, 0, 0, 2'b11, 10'd0, 1, 0, 0, "wr_decerr");
        do_txn(1, 64'h0200_4000, 64'h1, 8'h01, 0, 0, 0, 2'b00, 10'd9, 1, 0, 0, "wr_bad_id");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [9:0] id;
            id = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
            do_txn(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), id,
                   $urandom_range(0, 4) != 0, {$urandom, $urandom}, $urandom_range(0, 2), "random");
        end
    endtask

`ifdef CLINT_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int t;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 64'h0200_4000; req_wdata = 64'h3; req_strb = 8'hFF;
        @(negedge clk);
        req_valid = 0; aw_ready = 1; w_ready = 1;
        @(negedge clk);
        aw_ready = 0; w_ready = 0;
        t = 2;
        while (rsp_valid !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t !== 10 || rsp_err !== 1'b1 || rsp_rdata !== 64'd0 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_rsp cycle=%0d err=%b rdata=%h timeout=%b exp cycle=10 err=1 rdata=0 timeout=1", t, rsp_err, rsp_rdata, timeout);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (b_ready !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_drain b_ready=%b req_ready=%b rsp_valid=%b exp 1/0/0", b_ready, req_ready, rsp_valid);
        end
        b_valid = 1; b_resp = 0; b_id = 0;
        @(negedge clk);
        b_valid = 0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_after req_ready=%b rsp_valid=%b timeout=%b exp 1/0/1", req_ready, rsp_valid, timeout);
        end
        do_txn(0, 64'h0200_BFF8, 0, 0, 0, 0, 0, 2'b00, 10'd0, 1, 64'h99, 0, "after_timeout");
    endtask
`else
    task automatic test_timeout();
        do_txn(1, 64'h0200_4000, 64'h3, 8'hFF, 0, 0, 40, 2'b00, 10'd0, 1, 0, 0, "no_timeout_wait");
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_tied got=%b exp=0", timeout);
        end
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 64'h0200_4000; req_wdata = 64'hAB; req_strb = 8'hFF;
        @(negedge clk);
        req_valid = 0; aw_ready = 1; w_ready = 1;
        @(negedge clk);
        aw_ready = 0; w_ready = 0;
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_wr_resp b_ready=%b exp=1", b_ready);
        end
        rstn = 0;
        #1;
        checks++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_valids got=%b exp=000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid});
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        b_valid = 1; b_resp = 0; b_id = 0;
        @(negedge clk);
        b_valid = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 64'd0 || b_ready !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_after req_ready=%b rsp_valid=%b err=%b rdata=%h b_ready=%b exp 1/0/0/0/0", req_ready, rsp_valid, rsp_err, rsp_rdata, b_ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid();
        do_txn(0, 64'h0200_BFF8, 0, 0, 0, 0, 0, 2'b00, 10'd0, 1, 64'hCAFE, 0, "after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
